// File: rtl/tx_frame_ctrl.sv
// Transmit frame scheduler: byte FIFO feeding a bit sequencer that drives the encoder.
// Optional CRC-8 stage between payload and tail is enabled by defining TX_CRC8_EN.
module tx_frame_ctrl #(
    parameter int         PRE_LEN    = 8,
    parameter logic [7:0] SYNC_WORD  = 8'hB8,
    parameter int         PAY_BYTES  = 4,
    parameter int         TAIL_LEN   = 2,
    parameter int         GAP_LEN    = 4,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    input  logic       bit_tick,
    output logic       data_send,
    output logic       valid_send,
    output logic       frame_start,
    output logic       busy,
    output logic [7:0] frame_cnt
);
    // state | meaning
    // IDLE  | waiting for a tick with a full payload buffered
    // PRE   | alternating preamble (bit 0 already sent from IDLE)
    // SYNC  | sync word, MSB first
    // PAY   | payload bytes popped from the FIFO, MSB first
    // CRC   | CRC-8 over payload bits (TX_CRC8_EN only)
    // TAIL  | encoder flush zeros
    // GAP   | inter-frame idle ticks
    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SYNC, S_PAY, S_CRC, S_TAIL, S_GAP
    } state_t;

    localparam int         AW        = $clog2(FIFO_DEPTH);
    localparam int         PAY_BITS  = PAY_BYTES * 8;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] PAY_CNT  = (AW+1)'(PAY_BYTES);
    localparam logic [7:0] PRE_INIT  = (PRE_LEN > 1) ? 8'(PRE_LEN - 2) : 8'd7;
    localparam logic [7:0] PAY_INIT  = 8'(PAY_BITS - 1);
    localparam logic [7:0] TAIL_INIT = 8'(TAIL_LEN - 1);
    localparam logic [7:0] GAP_INIT  = 8'(GAP_LEN - 1);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;
    logic [7:0]    head;

    state_t     state, state_n;
    logic [7:0] bits_left, bits_left_n;
    logic [7:0] shreg, shreg_n;
    logic       hold;
    logic       bit_cur, emit, start, cnt_inc;
`ifdef TX_CRC8_EN
    logic [7:0] crc, crc_n;
`endif

    assign byte_ready = (count != FULL_CNT);
    assign push       = byte_valid & byte_ready;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= byte_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
        end
    end

    always_comb begin
        state_n     = state;
        bits_left_n = bits_left;
        shreg_n     = shreg;
        bit_cur     = 1'b0;
        emit        = 1'b0;
        start       = 1'b0;
        pop         = 1'b0;
        cnt_inc     = 1'b0;
`ifdef TX_CRC8_EN
        crc_n       = crc;
`endif
        if (bit_tick) begin
            case (state)
                S_IDLE: begin
                    if (count >= PAY_CNT) begin
                        start       = 1'b1;
                        emit        = 1'b1;
                        bit_cur     = 1'b1;
                        state_n     = (PRE_LEN > 1) ? S_PRE : S_SYNC;
                        bits_left_n = PRE_INIT;
`ifdef TX_CRC8_EN
                        crc_n       = 8'h00;
`endif
                    end
                end
                S_PRE: begin
                    // preamble alternates, so each bit is the inverse of the previous one
                    emit    = 1'b1;
                    bit_cur = ~hold;
                    if (bits_left == 8'd0) begin
                        state_n     = S_SYNC;
                        bits_left_n = 8'd7;
                    end else begin
                        bits_left_n = bits_left - 1'b1;
                    end
                end
                S_SYNC: begin
                    emit    = 1'b1;
                    bit_cur = SYNC_WORD[bits_left[2:0]];
                    if (bits_left == 8'd0) begin
                        state_n     = S_PAY;
                        bits_left_n = PAY_INIT;
                    end else begin
                        bits_left_n = bits_left - 1'b1;
                    end
                end
                S_PAY: begin
                    emit = 1'b1;
                    if (bits_left[2:0] == 3'd7) begin
                        pop     = 1'b1;
                        bit_cur = head[7];
                        shreg_n = {head[6:0], 1'b0};
                    end else begin
                        bit_cur = shreg[7];
                        shreg_n = {shreg[6:0], 1'b0};
                    end
`ifdef TX_CRC8_EN
                    crc_n = {crc[6:0], 1'b0} ^ ({8{crc[7] ^ bit_cur}} & 8'h07);
`endif
                    if (bits_left == 8'd0) begin
`ifdef TX_CRC8_EN
                        state_n     = S_CRC;
                        bits_left_n = 8'd7;
`else
                        state_n     = S_TAIL;
                        bits_left_n = TAIL_INIT;
`endif
                    end else begin
                        bits_left_n = bits_left - 1'b1;
                    end
                end
`ifdef TX_CRC8_EN
                S_CRC: begin
                    emit    = 1'b1;
                    bit_cur = crc[7];
                    crc_n   = {crc[6:0], 1'b0};
                    if (bits_left == 8'd0) begin
                        state_n     = S_TAIL;
                        bits_left_n = TAIL_INIT;
                    end else begin
                        bits_left_n = bits_left - 1'b1;
                    end
                end
`endif
                S_TAIL: begin
                    emit = 1'b1;
                    if (bits_left == 8'd0) begin
                        state_n     = S_GAP;
                        bits_left_n = GAP_INIT;
                        cnt_inc     = 1'b1;
                    end else begin
                        bits_left_n = bits_left - 1'b1;
                    end
                end
                S_GAP: begin
                    if (bits_left == 8'd0) state_n = S_IDLE;
                    else                   bits_left_n = bits_left - 1'b1;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            bits_left <= '0;
            shreg     <= '0;
            hold      <= 1'b0;
            frame_cnt <= '0;
`ifdef TX_CRC8_EN
            crc       <= '0;
`endif
        end else begin
            state     <= state_n;
            bits_left <= bits_left_n;
            shreg     <= shreg_n;
            if (bit_tick) hold <= bit_cur;
            if (cnt_inc)  frame_cnt <= frame_cnt + 1'b1;
`ifdef TX_CRC8_EN
            crc       <= crc_n;
`endif
        end
    end

    // bit goes out combinationally on the tick itself; between ticks the last bit is held
    assign data_send   = emit ? bit_cur : hold;
    assign valid_send  = emit;
    assign frame_start = start;
    assign busy        = (state != S_IDLE);

endmodule
